// File: rtl/dest_reg_pipe.sv
// Destination-register tracking through EX/MEM and MEM/WB, with operand
// forwarding selects, load-use stall detection and a saturating stall counter.
module dest_reg_pipe #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [REG_ADDR_W-1:0] EX_DEST,
  input  logic                  EX_REGWRITE,
  input  logic                  EX_MEMREAD,
  input  logic [REG_ADDR_W-1:0] EX_RS,
  input  logic [REG_ADDR_W-1:0] EX_RT,
  input  logic [REG_ADDR_W-1:0] ID_RS,
  input  logic [REG_ADDR_W-1:0] ID_RT,
  input  logic                  ID_USES_RT,
  input  logic                  HOLD,
  input  logic                  FLUSH,
  output logic [REG_ADDR_W-1:0] MEM_DEST,
  output logic                  MEM_REGWRITE,
  output logic                  MEM_MEMREAD,
  output logic [REG_ADDR_W-1:0] WB_DEST,
  output logic                  WB_REGWRITE,
  output logic [1:0]            FWD_A,
  output logic [1:0]            FWD_B,
  output logic                  LOAD_USE_STALL,
  output logic [CNT_W-1:0]      STALL_CNT
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [REG_ADDR_W-1:0] mem_dest_q, mem_dest_d;
  logic                  mem_regwrite_q, mem_regwrite_d;
  logic                  mem_memread_q, mem_memread_d;
  logic [REG_ADDR_W-1:0] wb_dest_q, wb_dest_d;
  logic                  wb_regwrite_q, wb_regwrite_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic                  load_use_stall;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] mem_dest,
    input logic                  mem_wr,
    input logic [REG_ADDR_W-1:0] wb_dest,
    input logic                  wb_wr
  );
    fwd_sel = 2'b00;
    if (mem_wr && (mem_dest != '0) && (mem_dest == src)) begin
      fwd_sel = 2'b10;
    end else if (wb_wr && (wb_dest != '0) && (wb_dest == src)) begin
      fwd_sel = 2'b01;
    end
  endfunction

  always_comb begin
    load_use_stall = EX_MEMREAD && (EX_DEST != '0) &&
                     ((EX_DEST == ID_RS) || (ID_USES_RT && (EX_DEST == ID_RT)));
  end

  // HOLD freezes everything, including a coincident FLUSH and the counter.
  always_comb begin
    mem_dest_d     = mem_dest_q;
    mem_regwrite_d = mem_regwrite_q;
    mem_memread_d  = mem_memread_q;
    wb_dest_d      = wb_dest_q;
    wb_regwrite_d  = wb_regwrite_q;
    stall_cnt_d    = stall_cnt_q;
    if (!HOLD) begin
      wb_dest_d     = mem_dest_q;
      wb_regwrite_d = mem_regwrite_q;
      if (FLUSH) begin
        mem_dest_d     = '0;
        mem_regwrite_d = 1'b0;
        mem_memread_d  = 1'b0;
      end else begin
        mem_dest_d     = EX_DEST;
        mem_regwrite_d = EX_REGWRITE;
        mem_memread_d  = EX_MEMREAD;
      end
      if (load_use_stall && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_dest_q     <= '0;
      mem_regwrite_q <= 1'b0;
      mem_memread_q  <= 1'b0;
      wb_dest_q      <= '0;
      wb_regwrite_q  <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      mem_dest_q     <= mem_dest_d;
      mem_regwrite_q <= mem_regwrite_d;
      mem_memread_q  <= mem_memread_d;
      wb_dest_q      <= wb_dest_d;
      wb_regwrite_q  <= wb_regwrite_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign MEM_DEST       = mem_dest_q;
  assign MEM_REGWRITE   = mem_regwrite_q;
  assign MEM_MEMREAD    = mem_memread_q;
  assign WB_DEST        = wb_dest_q;
  assign WB_REGWRITE    = wb_regwrite_q;
  assign STALL_CNT      = stall_cnt_q;
  assign LOAD_USE_STALL = load_use_stall;
  assign FWD_A = fwd_sel(EX_RS, mem_dest_q, mem_regwrite_q, wb_dest_q, wb_regwrite_q);
  assign FWD_B = fwd_sel(EX_RT, mem_dest_q, mem_regwrite_q, wb_dest_q, wb_regwrite_q);

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Bench for dest_reg_pipe: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_dest_reg_pipe;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [4:0] EX_DEST, EX_RS, EX_RT, ID_RS, ID_RT;
  logic       EX_REGWRITE, EX_MEMREAD, ID_USES_RT, HOLD, FLUSH;

  logic [4:0]  mem_dest, wb_dest, mem_dest_s, wb_dest_s;
  logic        mem_rw, mem_mr, wb_rw, mem_rw_s, mem_mr_s, wb_rw_s;
  logic [1:0]  fwd_a, fwd_b, fwd_a_s, fwd_b_s;
  logic        stall, stall_s;
  logic [15:0] cnt;
  logic [1:0]  cnt_s;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  dest_reg_pipe #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .EX_DEST(EX_DEST), .EX_REGWRITE(EX_REGWRITE),
    .EX_MEMREAD(EX_MEMREAD), .EX_RS(EX_RS), .EX_RT(EX_RT), .ID_RS(ID_RS),
    .ID_RT(ID_RT), .ID_USES_RT(ID_USES_RT), .HOLD(HOLD), .FLUSH(FLUSH),
    .MEM_DEST(mem_dest), .MEM_REGWRITE(mem_rw), .MEM_MEMREAD(mem_mr),
    .WB_DEST(wb_dest), .WB_REGWRITE(wb_rw), .FWD_A(fwd_a), .FWD_B(fwd_b),
    .LOAD_USE_STALL(stall), .STALL_CNT(cnt)
  );

  // Narrow-counter instance so saturation is reachable.
  dest_reg_pipe #(.REG_ADDR_W(5), .CNT_W(2)) dut_s (
    .CLK(CLK), .RESET(RESET), .EX_DEST(EX_DEST), .EX_REGWRITE(EX_REGWRITE),
    .EX_MEMREAD(EX_MEMREAD), .EX_RS(EX_RS), .EX_RT(EX_RT), .ID_RS(ID_RS),
    .ID_RT(ID_RT), .ID_USES_RT(ID_USES_RT), .HOLD(HOLD), .FLUSH(FLUSH),
    .MEM_DEST(mem_dest_s), .MEM_REGWRITE(mem_rw_s), .MEM_MEMREAD(mem_mr_s),
    .WB_DEST(wb_dest_s), .WB_REGWRITE(wb_rw_s), .FWD_A(fwd_a_s), .FWD_B(fwd_b_s),
    .LOAD_USE_STALL(stall_s), .STALL_CNT(cnt_s)
  );

  // clock / reset
  always #10 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  logic [4:0] m_mem_dest = '0, m_wb_dest = '0;
  logic       m_mem_rw = 1'b0, m_mem_mr = 1'b0, m_wb_rw = 1'b0;
  int         m_cnt = 0, m_cnt_s = 0;

  function automatic logic model_stall();
    return EX_MEMREAD && EX_DEST != 0 &&
           (EX_DEST == ID_RS || (ID_USES_RT && EX_DEST == ID_RT));
  endfunction

  // In-flight writers, youngest first; the first live match supplies the operand.
  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    logic [4:0] dst[2];
    logic       wr[2];
    logic [1:0] code[2];
    dst = '{m_mem_dest, m_wb_dest};
    wr  = '{m_mem_rw, m_wb_rw};
    code = '{2'b10, 2'b01};
    for (int s = 0; s < 2; s++)
      if (wr[s] && dst[s] != 0 && dst[s] == src) return code[s];
    return 2'b00;
  endfunction

  always @(posedge CLK) begin
    if (RESET) begin
      m_mem_dest <= '0; m_mem_rw <= 1'b0; m_mem_mr <= 1'b0;
      m_wb_dest <= '0; m_wb_rw <= 1'b0; m_cnt <= 0; m_cnt_s <= 0;
    end else if (!HOLD) begin
      m_wb_dest <= m_mem_dest;
      m_wb_rw   <= m_mem_rw;
      m_mem_dest <= FLUSH ? 5'd0 : EX_DEST;
      m_mem_rw   <= FLUSH ? 1'b0 : EX_REGWRITE;
      m_mem_mr   <= FLUSH ? 1'b0 : EX_MEMREAD;
      if (model_stall()) begin
        m_cnt   <= (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
        m_cnt_s <= (m_cnt_s + 1 > 3) ? 3 : m_cnt_s + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("mem_dest", 32'(mem_dest), 32'(m_mem_dest));
      chk("mem_regwrite", 32'(mem_rw), 32'(m_mem_rw));
      chk("mem_memread", 32'(mem_mr), 32'(m_mem_mr));
      chk("wb_dest", 32'(wb_dest), 32'(m_wb_dest));
      chk("wb_regwrite", 32'(wb_rw), 32'(m_wb_rw));
      chk("fwd_a", 32'(fwd_a), 32'(model_fwd(EX_RS)));
      chk("fwd_b", 32'(fwd_b), 32'(model_fwd(EX_RT)));
      chk("load_use_stall", 32'(stall), 32'(model_stall()));
      chk("stall_cnt", 32'(cnt), 32'(m_cnt));
      chk("stall_cnt_narrow", 32'(cnt_s), 32'(m_cnt_s));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_ex(input logic [4:0] d, input logic rw, input logic mr,
                        input logic [4:0] rs, input logic [4:0] rt);
    EX_DEST = d; EX_REGWRITE = rw; EX_MEMREAD = mr; EX_RS = rs; EX_RT = rt;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic uses);
    ID_RS = rs; ID_RT = rt; ID_USES_RT = uses;
  endtask

  initial begin
    RESET = 1'b1; HOLD = 1'b0; FLUSH = 1'b0;
    set_ex(0, 0, 0, 0, 0);
    set_id(0, 0, 0);
    tick(); tick();
    RESET = 1'b0;
    cmp_en = 1'b1;

    // reset clears in-flight destinations
    set_ex(9, 1, 0, 0, 0);
    tick(); tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    set_ex(0, 0, 0, 9, 0);
    settle();
    chk("t1_mem_dest", 32'(mem_dest), 0);
    chk("t1_mem_rw", 32'(mem_rw), 0);
    chk("t1_wb_dest", 32'(wb_dest), 0);
    chk("t1_wb_rw", 32'(wb_rw), 0);
    chk("t1_cnt", 32'(cnt), 0);
    chk("t1_fwd_a", 32'(fwd_a), 32'(2'b00));

    // MEM then WB forwarding
    set_ex(5, 1, 0, 0, 0);
    tick();
    set_ex(0, 0, 0, 5, 0);
    settle();
    chk("t2_fwd_a_mem", 32'(fwd_a), 32'(2'b10));
    tick();
    set_ex(0, 0, 0, 0, 5);
    settle();
    chk("t2_fwd_b_wb", 32'(fwd_b), 32'(2'b01));
    tick();
    settle();
    chk("t2_fwd_b_none", 32'(fwd_b), 32'(2'b00));

    // MEM beats WB
    set_ex(7, 1, 0, 0, 0);
    tick(); tick();
    set_ex(7, 1, 0, 7, 7);
    settle();
    chk("t3_fwd_a", 32'(fwd_a), 32'(2'b10));
    chk("t3_fwd_b", 32'(fwd_b), 32'(2'b10));

    // reg 0 is piped but never forwarded
    set_ex(0, 1, 0, 0, 0);
    tick();
    settle();
    chk("t4_fwd_a", 32'(fwd_a), 32'(2'b00));
    chk("t4_mem_dest", 32'(mem_dest), 0);
    chk("t4_mem_rw", 32'(mem_rw), 1);

    // load-use stall and the flush that follows it
    set_ex(4, 1, 0, 0, 0);
    tick();
    set_ex(8, 1, 1, 0, 0);
    set_id(3, 8, 1);
    settle();
    chk("t5_stall_rt", 32'(stall), 1);
    ID_USES_RT = 1'b0;
    settle();
    chk("t5_stall_no_rt", 32'(stall), 0);
    ID_USES_RT = 1'b1;
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    set_id(0, 0, 0);
    settle();
    chk("t5_mem_rw", 32'(mem_rw), 0);
    chk("t5_mem_mr", 32'(mem_mr), 0);
    chk("t5_wb_dest", 32'(wb_dest), 4);
    chk("t5_wb_rw", 32'(wb_rw), 1);
    chk("t5_cnt", 32'(cnt), 1);

    // counter saturation, HOLD edge not counted, HOLD+FLUSH freezes
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    set_ex(8, 1, 1, 0, 0);
    set_id(8, 0, 0);
    for (int i = 0; i < 5; i++) begin
      HOLD = (i == 2);
      tick();
    end
    HOLD = 1'b0;
    settle();
    chk("t6_cnt_wide", 32'(cnt), 4);
    chk("t6_cnt_sat", 32'(cnt_s), 3);
    set_ex(12, 0, 0, 0, 0);
    set_id(0, 0, 0);
    HOLD = 1'b1; FLUSH = 1'b1;
    tick();
    HOLD = 1'b0; FLUSH = 1'b0;
    settle();
    chk("t6_mem_dest", 32'(mem_dest), 8);
    chk("t6_mem_rw", 32'(mem_rw), 1);
    chk("t6_mem_mr", 32'(mem_mr), 1);
    chk("t6_wb_dest", 32'(wb_dest), 8);
    chk("t6_wb_rw", 32'(wb_rw), 1);
    chk("t6_cnt_sat_held", 32'(cnt_s), 3);

    // randomized traffic over a small register range to provoke matches
    for (int n = 0; n < 3000; n++) begin
      set_ex(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      set_id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      HOLD  = ($urandom_range(0, 7) == 0);
      FLUSH = ($urandom_range(0, 5) == 0);
      RESET = ($urandom_range(0, 299) == 0);
      tick();
    end
    RESET = 1'b0; HOLD = 1'b0; FLUSH = 1'b0;
    @(negedge CLK);
    #1;
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
